// File: rtl/demux1_8_buf_pkg.sv
// Shared constants, lane-state encoding and a popcount helper for the
// buffered 1-to-8 demultiplexer.
package demux1_8_buf_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;
    localparam int COUNT_W   = 4;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    // Number of set bits in a lane vector, sized to the occupancy counter.
    function automatic logic [COUNT_W-1:0] lane_popcount(input logic [NUM_LANES-1:0] vec);
        logic [COUNT_W-1:0] cnt;
        cnt = {COUNT_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt = cnt + {{(COUNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux1_8_buf_decoder3_8.sv
// 3-to-8 one-hot decoder with enable; forms the per-lane write strobe.
module decoder3_8
    import demux1_8_buf_pkg::*;
(
    input  logic [SEL_W-1:0]     sel,
    input  logic                 en,
    output logic [NUM_LANES-1:0] onehot
);

    // Decode sel into a single set bit, all zero while disabled.
    always_comb begin
        onehot = {NUM_LANES{1'b0}};
        if (en) begin
            onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << sel;
        end else begin
            onehot = {NUM_LANES{1'b0}};
        end
    end

endmodule

// File: rtl/demux1_8_buf.sv
// Buffered 1-to-8 demux: one input word steered into eight holding lanes,
// each held until its consumer acks; producer stalls on an occupied lane.
module demux1_8_buf
    import demux1_8_buf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out1,
    output logic [WIDTH-1:0]     out2,
    output logic [WIDTH-1:0]     out3,
    output logic [WIDTH-1:0]     out4,
    output logic [WIDTH-1:0]     out5,
    output logic [WIDTH-1:0]     out6,
    output logic [WIDTH-1:0]     out7,
    output logic [WIDTH-1:0]     out8,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ack,
    output logic [COUNT_W-1:0]   count
);

    logic [NUM_LANES-1:0] wr_s;
    logic [NUM_LANES-1:0] accept_s;
    logic [NUM_LANES-1:0] consume_s;
    logic [NUM_LANES-1:0] valid_s;
    logic                 ready_s;
    logic [COUNT_W-1:0]   count_r;
    logic [COUNT_W-1:0]   count_next_s;
    logic [WIDTH-1:0]     lane_data_r  [NUM_LANES];
    lane_state_e          lane_state_r [NUM_LANES];

    decoder3_8 u_decoder3_8 (
        .sel    (sel),
        .en     (in_valid),
        .onehot (wr_s)
    );

    // Addressed lane can take a word if empty or being drained this cycle.
    always_comb begin
        ready_s = 1'b0;
        if (!valid_s[sel] || out_ack[sel]) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s  = wr_s & {NUM_LANES{ready_s}};
    assign consume_s = valid_s & out_ack;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign valid_s[k] = (lane_state_r[k] == LANE_FULL);

        // Lane holding register: a refill wins over a simultaneous consume.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_data_r[k]  <= {WIDTH{1'b0}};
                lane_state_r[k] <= LANE_EMPTY;
            end else if (accept_s[k]) begin
                lane_data_r[k]  <= in;
                lane_state_r[k] <= LANE_FULL;
            end else if (consume_s[k]) begin
                lane_state_r[k] <= LANE_EMPTY;
            end else begin
                lane_state_r[k] <= lane_state_r[k];
            end
        end
    end

    // Occupancy delta: +1 per accept, -1 per consume, summed per cycle.
    always_comb begin
        count_next_s = count_r;
        count_next_s = count_r + lane_popcount(accept_s) - lane_popcount(consume_s);
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {COUNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = valid_s;
    assign count     = count_r;
    assign out1      = lane_data_r[0];
    assign out2      = lane_data_r[1];
    assign out3      = lane_data_r[2];
    assign out4      = lane_data_r[3];
    assign out5      = lane_data_r[4];
    assign out6      = lane_data_r[5];
    assign out7      = lane_data_r[6];
    assign out8      = lane_data_r[7];

endmodule

// File: tb/tb_demux1_8_buf.sv
// Self-checking bench for demux1_8_buf: directed scenarios plus randomized
// stress against a lane-array reference model.
module tb_demux1_8_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic [2:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out1, out2, out3, out4, out5, out6, out7, out8;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_data [8];
    bit          m_full [8];

    demux1_8_buf #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out8      (out8),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_lane(input int k);
        case (k)
            0: return out1;
            1: return out2;
            2: return out3;
            3: return out4;
            4: return out5;
            5: return out6;
            6: return out7;
            default: return out8;
        endcase
    endfunction

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int k = 0; k < 8; k++) if (m_full[k]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_data[k] = 16'h0000;
            m_full[k] = 1'b0;
        end
    endtask

    task automatic check_state();
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("out%0d", k + 1), {16'h0000, dut_lane(k)}, {16'h0000, m_data[k]});
        end
        check_val("out_valid", {24'h0, out_valid}, {24'h0, model_valid()});
        check_val("count", {28'h0, count}, model_count());
        check_val("count_popcount", {28'h0, count}, $countones(out_valid));
    endtask

    // One clock cycle: drive, check in_ready pre-edge, advance model, check state.
    task automatic cycle(input bit v, input logic [2:0] s, input logic [15:0] d, input logic [7:0] ack);
        bit exp_rdy;
        @(negedge clk);
        in_valid = v;
        sel      = s;
        in       = d;
        out_ack  = ack;
        #1;
        exp_rdy = !m_full[s] || ack[s];
        check_val("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (m_full[k] && ack[k]) m_full[k] = 1'b0;
        end
        if (v && exp_rdy) begin
            m_full[s] = 1'b1;
            m_data[s] = d;
        end
        #1;
        check_state();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        in_valid = 1'b0;
        out_ack  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        check_val("reset_out_valid", {24'h0, out_valid}, 32'h0);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #0.1;
            check_val("reset_in_ready", {31'h0, in_ready}, 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in       = 16'h0000;
        sel      = 3'd0;
        in_valid = 1'b0;
        out_ack  = 8'h00;
        model_reset();
        #12;
        check_state();
        check_val("reset_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        cycle(1'b0, 3'd0, 16'h0000, 8'h00);

        // Fill all lanes, then a blocked word to lane 2
        for (int s = 0; s < 8; s++) cycle(1'b1, 3'(s), 16'h00A0 + 16'(s), 8'h00);
        check_val("fill_valid", {24'h0, out_valid}, 32'hFF);
        check_val("fill_count", {28'h0, count}, 32'd8);
        check_val("fill_out8", {16'h0, out8}, 32'h00A7);
        cycle(1'b1, 3'd2, 16'hDEAD, 8'h00);
        check_val("blocked_out3", {16'h0, out3}, 32'h00A2);

        // Reset mid-run with three lanes FULL
        cycle(1'b0, 3'd0, 16'h0000, 8'hFF);
        cycle(1'b1, 3'd1, 16'h1111, 8'h00);
        cycle(1'b1, 3'd4, 16'h4444, 8'h00);
        cycle(1'b1, 3'd6, 16'h6666, 8'h00);
        check_val("pre_reset_count", {28'h0, count}, 32'd3);
        mid_reset();

        // Stall and release on lane 5
        cycle(1'b1, 3'd5, 16'h1234, 8'h00);
        cycle(1'b1, 3'd5, 16'hBEEF, 8'h00);
        check_val("stall_out6", {16'h0, out6}, 32'h1234);
        cycle(1'b1, 3'd5, 16'hBEEF, 8'h20);
        check_val("release_out6", {16'h0, out6}, 32'hBEEF);
        check_val("release_valid", {24'h0, out_valid}, 32'h20);
        check_val("release_count", {28'h0, count}, 32'd1);

        // Ack lane 0 while writing lane 7
        cycle(1'b0, 3'd0, 16'h0000, 8'hFF);
        cycle(1'b1, 3'd0, 16'h5555, 8'h00);
        cycle(1'b1, 3'd7, 16'h0F0F, 8'h01);
        check_val("ackwrite_valid", {24'h0, out_valid}, 32'h80);
        check_val("ackwrite_count", {28'h0, count}, 32'd1);

        // Spurious acks on empty lanes
        cycle(1'b0, 3'd0, 16'h0000, 8'hFF);
        cycle(1'b0, 3'd3, 16'h0000, 8'hFF);
        check_val("spurious_count", {28'h0, count}, 32'd0);
        check_val("spurious_valid", {24'h0, out_valid}, 32'h0);

        // Randomized stress
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  16'($urandom), 8'($urandom & $urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux1_8_buf.md
# demux1_8_buf

Buffered 1-to-8 demultiplexer: the return path for the 8:1 select muxes in the datapath. A single WIDTH-bit input word plus a 3-bit select is steered into one of eight per-lane holding registers. Each lane holds its word until its consumer acknowledges it. A valid/ready handshake on the input stalls the producer when the addressed lane is still occupied.

## Interface
Parameters:
- WIDTH, 16, data width of the input word and of each lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  input data word.
- sel  input  3  destination lane. 0 selects out1, 7 selects out8.
- in_valid  input  1  producer has a word on in/sel.
- in_ready  output  1  the addressed lane can accept this cycle. Combinational.
- out1..out8  output  WIDTH  lane holding registers.
- out_valid  output  8  bit k-1 is set while outk holds an unconsumed word.
- out_ack  input  8  bit k-1 means the consumer takes outk this cycle.
- count  output  4  number of occupied lanes, range 0..8.

## Operation
- Per-lane state is 1 bit, EMPTY (out_valid=0) or FULL (out_valid=1).
- in_ready = !out_valid[sel] || out_ack[sel]. A FULL lane that is being acked this cycle can be refilled in the same cycle.
- Accept: in_valid && in_ready.
  - On accept, out[sel] <= in and out_valid[sel] <= 1.
- Consume: out_valid[k] && out_ack[k].
  - Lane k goes EMPTY, unless the same cycle also has an accept on lane k.
  - In that case the lane stays FULL and holds the new data.
- out_ack on an EMPTY lane is ignored: no state change, no count change.
- Lanes are independent. An accept on lane j and consumes on any other lanes proceed in the same cycle.
- in and sel are don't-care while in_valid=0. Lane data does not change unless the lane accepts.
- count update rules:
  - count changes by +1 per accept.
  - count changes by −1 per consume.
  - All deltas in a cycle are summed.
  - count never exceeds 8 and never wraps below 0; the handshake rules guarantee this.
- count must equal popcount(out_valid) at every edge.

## Timing
- Reset, asynchronous on rst_n low:
  - out1..out8 = 0.
  - out_valid = 8'h00.
  - count = 0.
  - in_ready = 1 for any sel, since all lanes are EMPTY.
- Reset asserted mid-transfer discards all held words and any accept in progress. The first accept is possible on the first rising edge after rst_n deasserts.
- Latency: a word accepted at edge N appears on outk with out_valid[k-1]=1 after edge N.
- in_ready depends combinationally on sel, out_valid and out_ack. It is not registered.
- Throughput:
  - One word per cycle when successive words target different lanes.
  - One word per cycle to the same lane if the consumer acks every cycle.
- A producer holding in_valid=1 with in_ready=0 must keep in and sel stable until accept; the block does not latch them.

## Structure
- Shared package holds:
  - NUM_LANES = 8.
  - SEL_W = 3.
  - COUNT_W = 4.
  - the EMPTY/FULL lane-state encoding.
- Sub-module decoder3_8: sel and enable in, one-hot 8-bit out.
  - Used to form the per-lane write strobe: onehot(sel) & in_valid.
- The top level holds:
  - eight lane registers (generate loop).
  - the out_valid vector.
  - the count register with a popcount-delta adder, and the in_ready mux.

## Test plan
- Reset then idle: check out_valid=0, count=0, in_ready=1, all outk=0. Pulse rst_n low mid-run with 3 lanes FULL; expect all cleared immediately.
- Fill all lanes: send sel=0..7 with in=16'h00A0+sel, no acks. Expect out1..out8=00A0..00A7, out_valid=8'hFF, count=8. A further word to sel=2 shows in_ready=0 and out3 unchanged.
- Stall and release: lane 5 FULL (16'h1234). Present in=16'hBEEF, sel=5, in_valid held. Expect in_ready=0. Assert out_ack[5]; expect in_ready=1 that cycle, then out6=16'hBEEF, out_valid[5]=1, count unchanged.
- Simultaneous ack and write, different lanes: lane 0 FULL. In one cycle ack lane 0 and write sel=7, in=16'h0F0F. Expect out_valid=8'h80, count=1.
- Spurious ack: out_ack=8'hFF with all lanes EMPTY. Expect no change; count stays 0.
- Random stress over 10k cycles with a reference model. Check outputs, out_valid, count==popcount(out_valid), and no accept while the target lane is FULL and unacked.
